sync_tracker: RTL and testbench

- Parametrised successor to the sync-to-count block in the video pipeline. Takes raw HSync/VSync of either polarity and outputs delayed syncs, aligned Col/Row counters, an active-video flag and line/frame start strobes.
- Adds a lock state machine that checks frame length against the configured totals. Reports lock status and sync errors so downstream pattern/overlay blocks can gate output on a stable source.

---
 rtl/sync_tracker.sv | 206 ++++++++++++++++++++
 tb/tb_sync_tracker.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_tracker.sv
// -----------------------------------------------------------------------------
// sync_tracker
//
// Turns raw HSync/VSync (either polarity) into a 1-clock-delayed copy of the
// syncs plus aligned column/row counters, line/frame start strobes, an
// active-video flag and a lock indication. A small lock FSM compares the
// spacing of VSync leading edges against TOTAL_COLS*TOTAL_ROWS and reports
// violations as single-cycle error pulses.
//
// Ports:
//   i_Clk          pixel clock, everything on posedge
//   i_Reset        synchronous, active-high reset
//   i_HSync        raw horizontal sync (only delayed, never used for counting)
//   i_VSync        raw vertical sync; its asserting edge is the frame start
//   o_HSync        i_HSync delayed one clock, raw polarity
//   o_VSync        i_VSync delayed one clock, raw polarity
//   o_Col_Count    column position aligned with o_HSync/o_VSync
//   o_Row_Count    row position aligned with o_HSync/o_VSync
//   o_Line_Start   high while o_Col_Count == 0
//   o_Frame_Start  high while o_Col_Count == 0 and o_Row_Count == 0
//   o_Active       high while locked and inside the visible window
//   o_Locked       lock FSM is in LOCKED
//   o_Sync_Err     one-cycle pulse on a frame-length violation
//   o_Err_Count    (only with SYNC_TRACKER_ERR_CNT_EN) saturating error count
//
// Optional feature macro: SYNC_TRACKER_ERR_CNT_EN adds the 8-bit o_Err_Count
// port, which counts o_Sync_Err events, saturates at 255 and is cleared only
// by i_Reset.
//
// Handshake: none; this is a free-running streaming block, one pixel per clock.
//
// The FSM state is held in state_q (type state_e) for hierarchical probing.
// -----------------------------------------------------------------------------
module sync_tracker #(
   parameter int TOTAL_COLS       = 800,
   parameter int TOTAL_ROWS       = 525,
   parameter int ACTIVE_COLS      = 640,
   parameter int ACTIVE_ROWS      = 480,
   parameter bit SYNC_ACTIVE_HIGH = 1'b1,
   parameter int LOCK_FRAMES      = 2
) (
   input  logic                          i_Clk,
   input  logic                          i_Reset,
   input  logic                          i_HSync,
   input  logic                          i_VSync,
   output logic                          o_HSync,
   output logic                          o_VSync,
   output logic [$clog2(TOTAL_COLS)-1:0] o_Col_Count,
   output logic [$clog2(TOTAL_ROWS)-1:0] o_Row_Count,
   output logic                          o_Line_Start,
   output logic                          o_Frame_Start,
   output logic                          o_Active,
   output logic                          o_Locked,
   output logic                          o_Sync_Err
`ifdef SYNC_TRACKER_ERR_CNT_EN
   ,
   output logic [7:0]                    o_Err_Count
`endif
);

   localparam int COL_W = $clog2(TOTAL_COLS);
   localparam int ROW_W = $clog2(TOTAL_ROWS);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(TOTAL_COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TOTAL_ROWS - 1);
   // One extra bit so ACTIVE_* == 2**W still fits.
   localparam logic [COL_W:0]   COL_ACT  = (COL_W + 1)'(ACTIVE_COLS);
   localparam logic [ROW_W:0]   ROW_ACT  = (ROW_W + 1)'(ACTIVE_ROWS);
   localparam logic [3:0]       LOCK_N   = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_CHECK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [3:0]         good_q, good_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic               hsync_q, vsync_q;
   logic               vn_prev_q;
   logic               err_q, err_d;

   logic               vn;
   logic               fs;
   logic               at_end;

   // Internally VSync is always treated as active-high.
   assign vn     = SYNC_ACTIVE_HIGH ? i_VSync : ~i_VSync;
   assign fs     = vn & ~vn_prev_q;
   assign at_end = (col_q == COL_LAST) && (row_q == ROW_LAST);

   // Counters free-run in every state; FS realigns them. Without FS the
   // natural wrap at END is the flywheel back to (0,0).
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (fs) begin
         col_d = '0;
         row_d = '0;
      end else if (col_q == COL_LAST) begin
         col_d = '0;
         row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
         col_d = col_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      err_d   = 1'b0;
      unique case (state_q)
         ST_SEARCH: begin
            if (fs) begin
               state_d = ST_CHECK;
               good_d  = '0;
            end
         end
         ST_CHECK: begin
            if (fs && at_end) begin
               if ((good_q + 4'd1) == LOCK_N) begin
                  state_d = ST_LOCKED;
                  good_d  = '0;
               end else begin
                  good_d  = good_q + 4'd1;
               end
            end else if (fs) begin
               err_d   = 1'b1;
               good_d  = '0;
            end else if (at_end) begin
               err_d   = 1'b1;
               state_d = ST_SEARCH;
               good_d  = '0;
            end
         end
         ST_LOCKED: begin
            if (fs && !at_end) begin
               err_d   = 1'b1;
               state_d = ST_CHECK;
               good_d  = '0;
            end else if (!fs && at_end) begin
               err_d   = 1'b1;
               state_d = ST_SEARCH;
               good_d  = '0;
            end
         end
         default: begin
            state_d = ST_SEARCH;
            good_d  = '0;
         end
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         hsync_q   <= 1'b0;
         vsync_q   <= 1'b0;
         // Loading the live level means a VSync held through reset is not
         // mistaken for a fresh edge on release.
         vn_prev_q <= vn;
         col_q     <= '0;
         row_q     <= '0;
         state_q   <= ST_SEARCH;
         good_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         hsync_q   <= i_HSync;
         vsync_q   <= i_VSync;
         vn_prev_q <= vn;
         col_q     <= col_d;
         row_q     <= row_d;
         state_q   <= state_d;
         good_q    <= good_d;
         err_q     <= err_d;
      end
   end

   assign o_HSync       = hsync_q;
   assign o_VSync       = vsync_q;
   assign o_Col_Count   = col_q;
   assign o_Row_Count   = row_q;
   assign o_Locked      = (state_q == ST_LOCKED);
   assign o_Sync_Err    = err_q;
   // Strobes are held low while reset is asserted even though counts sit at 0.
   assign o_Line_Start  = ~i_Reset & (col_q == '0);
   assign o_Frame_Start = ~i_Reset & (col_q == '0) & (row_q == '0);
   assign o_Active      = o_Locked & ({1'b0, col_q} < COL_ACT) & ({1'b0, row_q} < ROW_ACT);

`ifdef SYNC_TRACKER_ERR_CNT_EN
   logic [7:0] err_cnt_q;

   // Counts on err_d so the count steps in the same cycle o_Sync_Err rises.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         err_cnt_q <= '0;
      end else if (err_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign o_Err_Count = err_cnt_q;
`endif

endmodule

// File: tb/tb_sync_tracker.sv
// -----------------------------------------------------------------------------
// tb_sync_tracker
//
// Two instances share one stimulus stream: dut_h sees active-high syncs and
// dut_l sees the same syncs inverted with SYNC_ACTIVE_HIGH=0, so both must
// report identical counts/lock/errors. A frame-position model (linear pixel
// index within a 60-clock frame) predicts every output.
// -----------------------------------------------------------------------------
module tb_sync_tracker;

   localparam int TC  = 10;
   localparam int TR  = 6;
   localparam int AC  = 8;
   localparam int AR  = 4;
   localparam int LF  = 2;
   localparam int FRAME_LEN = TC * TR;

   localparam int MODE_SEARCH = 0;
   localparam int MODE_CHECK  = 1;
   localparam int MODE_LOCKED = 2;

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   logic rst, hs, vs;
   logic hs_n, vs_n;

   always #5 clk = ~clk;

   assign hs_n = ~hs;
   assign vs_n = ~vs;

   logic       h_hs, h_vs, h_ls, h_fs, h_act, h_lock, h_err;
   logic [3:0] h_col;
   logic [2:0] h_row;
   logic       l_hs, l_vs, l_ls, l_fs, l_act, l_lock, l_err;
   logic [3:0] l_col;
   logic [2:0] l_row;
`ifdef SYNC_TRACKER_ERR_CNT_EN
   logic [7:0] h_ecnt, l_ecnt;
`endif

   sync_tracker #(
      .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
      .SYNC_ACTIVE_HIGH(1'b1), .LOCK_FRAMES(LF)
   ) dut_h (
      .i_Clk(clk), .i_Reset(rst), .i_HSync(hs), .i_VSync(vs),
      .o_HSync(h_hs), .o_VSync(h_vs), .o_Col_Count(h_col), .o_Row_Count(h_row),
      .o_Line_Start(h_ls), .o_Frame_Start(h_fs), .o_Active(h_act),
      .o_Locked(h_lock), .o_Sync_Err(h_err)
`ifdef SYNC_TRACKER_ERR_CNT_EN
      , .o_Err_Count(h_ecnt)
`endif
   );

   sync_tracker #(
      .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
      .SYNC_ACTIVE_HIGH(1'b0), .LOCK_FRAMES(LF)
   ) dut_l (
      .i_Clk(clk), .i_Reset(rst), .i_HSync(hs_n), .i_VSync(vs_n),
      .o_HSync(l_hs), .o_VSync(l_vs), .o_Col_Count(l_col), .o_Row_Count(l_row),
      .o_Line_Start(l_ls), .o_Frame_Start(l_fs), .o_Active(l_act),
      .o_Locked(l_lock), .o_Sync_Err(l_err)
`ifdef SYNC_TRACKER_ERR_CNT_EN
      , .o_Err_Count(l_ecnt)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   int m_pos;       // pixel index within the frame, 0..FRAME_LEN-1
   int m_mode;
   int m_good;
   bit m_err;
   bit m_vprev;
   bit m_hs, m_vs;  // raw (active-high stream) syncs, one clock late
   bit m_sync_ok;   // 0 right after a reset edge: sync outputs forced low
   bit m_rst;       // reset level applied for the current cycle
   int m_ecnt;

   task automatic model_step(input bit h, input bit v, input bit r);
      bit fs, at_end;
      fs = v && !m_vprev;
      if (r) begin
         m_vprev = v; m_pos = 0; m_mode = MODE_SEARCH; m_good = 0;
         m_err = 1'b0; m_sync_ok = 1'b0; m_hs = 1'b0; m_vs = 1'b0; m_ecnt = 0;
      end else begin
         at_end = (m_pos == FRAME_LEN - 1);
         m_err  = 1'b0;
         if (m_mode == MODE_SEARCH) begin
            if (fs) begin m_mode = MODE_CHECK; m_good = 0; end
         end else if (fs && at_end) begin
            if (m_mode == MODE_CHECK) begin
               m_good++;
               if (m_good == LF) m_mode = MODE_LOCKED;
            end
         end else if (fs) begin
            m_err = 1'b1; m_mode = MODE_CHECK; m_good = 0;
         end else if (at_end) begin
            m_err = 1'b1; m_mode = MODE_SEARCH; m_good = 0;
         end
         m_pos = fs ? 0 : (m_pos + 1) % FRAME_LEN;
         m_vprev = v; m_hs = h; m_vs = v; m_sync_ok = 1'b1;
         if (m_err && m_ecnt < 255) m_ecnt++;
      end
      m_rst = r;
   endtask

   function automatic logic [13:0] exp_vec(input bit lo);
      logic [3:0] c;
      logic [2:0] rw;
      logic       lk;
      c  = 4'(m_pos % TC);
      rw = 3'(m_pos / TC);
      lk = (m_mode == MODE_LOCKED);
      return {m_sync_ok & (m_hs ^ lo), m_sync_ok & (m_vs ^ lo), c, rw,
              (!m_rst && c == 4'd0), (!m_rst && m_pos == 0),
              (lk && c < 4'(AC) && rw < 3'(AR)), lk, m_err};
   endfunction

   function automatic logic [13:0] dut_vec(input bit lo);
      if (lo) return {l_hs, l_vs, l_col, l_row, l_ls, l_fs, l_act, l_lock, l_err};
      return {h_hs, h_vs, h_col, h_row, h_ls, h_fs, h_act, h_lock, h_err};
   endfunction

   // ---------------- driver tasks ----------------
   // Applies inputs, takes one rising edge, advances the model, and returns
   // at the following falling edge where outputs are sampled.
   task automatic drive_cycle(input bit h, input bit v, input bit r);
      hs = h; vs = v; rst = r;
      @(posedge clk);
      model_step(h, v, r);
      @(negedge clk);
   endtask

   // Frame cycles from..to-1; VSync is asserted in cycles 0 and 1.
   task automatic drive_run(input int from, input int to);
      for (int i = from; i < to; i++) drive_cycle(1'($urandom_range(0, 1)), (i < 2), 1'b0);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b1, 1'b1, 1'b1);
         n_tests++;
         if ({dut_vec(0), dut_vec(1)} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_outputs cyc=%0d got=%b/%b required all zero", i, dut_vec(0), dut_vec(1));
         end
      end
      // VSync still asserted on release: no frame start, counts just run.
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b0, 1'b1, 1'b0);
         n_tests++;
         if ({h_col, h_row, h_err, l_col, l_row, l_err} !== {4'(i + 1), 3'd0, 1'b0, 4'(i + 1), 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_vs_held cyc=%0d got col=%0d row=%0d err=%b required col=%0d row=0 err=0",
                     i, h_col, h_row, h_err, i + 1);
         end
      end
      for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_clean_frames();
      int n_act, n_ls, n_fs;
      n_act = 0; n_ls = 0; n_fs = 0;
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < FRAME_LEN; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), (i < 2), 1'b0);
            n_tests++;
            if ({dut_vec(0), dut_vec(1)} !== {exp_vec(0), exp_vec(1)}) begin
               n_fail++;
               $display("FAIL clean_model f=%0d i=%0d got=%b/%b required=%b/%b",
                        f, i, dut_vec(0), dut_vec(1), exp_vec(0), exp_vec(1));
            end
            if (f == 0 && i == 0) begin
               n_tests++;
               if ({h_col, h_row, h_fs, h_lock, l_col, l_row, l_fs} !== {4'd0, 3'd0, 1'b1, 1'b0, 4'd0, 3'd0, 1'b1}) begin
                  n_fail++;
                  $display("FAIL first_fs got col=%0d row=%0d fs=%b lock=%b required (0,0) fs=1 lock=0",
                           h_col, h_row, h_fs, h_lock);
               end
            end
            if (f == 1 && i == FRAME_LEN - 1) begin
               n_tests++;
               if ({h_lock, l_lock} !== 2'b00) begin
                  n_fail++;
                  $display("FAIL lock_early got=%b%b required 00", h_lock, l_lock);
               end
            end
            if (f == 2 && i == 0) begin
               n_tests++;
               if ({h_lock, l_lock} !== 2'b11) begin
                  n_fail++;
                  $display("FAIL lock_third_fs got=%b%b required 11", h_lock, l_lock);
               end
            end
            if (f == 3) begin
               n_act += int'(h_act); n_ls += int'(h_ls); n_fs += int'(h_fs);
            end
         end
      end
      n_tests++;
      if ({n_act, n_ls, n_fs} !== {32'(AC * AR), 32'(TR), 32'd1}) begin
         n_fail++;
         $display("FAIL locked_frame_strobes got act=%0d ls=%0d fs=%0d required act=%0d ls=%0d fs=1",
                  n_act, n_ls, n_fs, AC * AR, TR);
      end
   endtask

   task automatic test_early_frame();
      drive_run(0, 35);
      n_tests++;
      if ({h_col, h_row, h_lock} !== {4'd4, 3'd3, 1'b1}) begin
         n_fail++;
         $display("FAIL early_pre got col=%0d row=%0d lock=%b required (4,3) lock=1", h_col, h_row, h_lock);
      end
      drive_cycle(1'b0, 1'b1, 1'b0);
      n_tests++;
      if ({h_err, h_col, h_row, h_lock, l_err, l_col, l_row, l_lock} !==
          {1'b1, 4'd0, 3'd0, 1'b0, 1'b1, 4'd0, 3'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL early_err got err=%b col=%0d row=%0d lock=%b required err=1 (0,0) lock=0",
                  h_err, h_col, h_row, h_lock);
      end
      drive_cycle(1'b0, 1'b1, 1'b0);
      n_tests++;
      if ({h_err, l_err} !== 2'b00) begin
         n_fail++;
         $display("FAIL early_err_width got=%b%b required 00", h_err, l_err);
      end
      drive_run(2, FRAME_LEN);
      drive_run(0, FRAME_LEN);
      n_tests++;
      if ({h_lock, l_lock} !== 2'b00) begin
         n_fail++;
         $display("FAIL early_relock_pre got=%b%b required 00", h_lock, l_lock);
      end
      drive_cycle(1'b0, 1'b1, 1'b0);
      n_tests++;
      if ({h_lock, l_lock} !== 2'b11) begin
         n_fail++;
         $display("FAIL early_relock got=%b%b required 11", h_lock, l_lock);
      end
      drive_run(1, FRAME_LEN);
   endtask

   task automatic test_missing_vsync();
      n_tests++;
      if ({h_col, h_row, h_lock} !== {4'd9, 3'd5, 1'b1}) begin
         n_fail++;
         $display("FAIL missing_pre got col=%0d row=%0d lock=%b required (9,5) lock=1", h_col, h_row, h_lock);
      end
      drive_cycle(1'b0, 1'b0, 1'b0);
      n_tests++;
      if ({h_err, h_col, h_row, h_lock, l_err, l_lock} !== {1'b1, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL missing_err got err=%b col=%0d row=%0d lock=%b required err=1 (0,0) lock=0",
                  h_err, h_col, h_row, h_lock);
      end
      drive_cycle(1'b0, 1'b0, 1'b0);
      n_tests++;
      if ({h_err, h_col} !== {1'b0, 4'd1}) begin
         n_fail++;
         $display("FAIL missing_after got err=%b col=%0d required err=0 col=1", h_err, h_col);
      end
      for (int i = 0; i < 8; i++) drive_cycle(1'b0, 1'b0, 1'b0);
      drive_run(0, FRAME_LEN);
      drive_run(0, FRAME_LEN);
      drive_cycle(1'b0, 1'b1, 1'b0);
      n_tests++;
      if ({h_lock, l_lock, h_err} !== 3'b110) begin
         n_fail++;
         $display("FAIL missing_relock got lock=%b%b err=%b required lock=11 err=0", h_lock, l_lock, h_err);
      end
      drive_run(1, FRAME_LEN);
   endtask

   task automatic test_mid_reset();
      drive_run(0, 25);
      n_tests++;
      if (h_lock !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_pre got lock=%b required 1", h_lock);
      end
      drive_cycle(1'b1, 1'b0, 1'b1);
      n_tests++;
      if ({dut_vec(0), dut_vec(1)} !== 28'd0) begin
         n_fail++;
         $display("FAIL midreset_zero got=%b/%b required all zero", dut_vec(0), dut_vec(1));
      end
      drive_cycle(1'b0, 1'b0, 1'b0);
      n_tests++;
      if ({h_col, h_row, h_lock, h_err, l_col, l_lock} !== {4'd1, 3'd0, 1'b0, 1'b0, 4'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL midreset_restart got col=%0d row=%0d lock=%b err=%b required col=1 row=0 lock=0 err=0",
                  h_col, h_row, h_lock, h_err);
      end
   endtask

   task automatic test_random_frames();
      int len, pw, kind;
      for (int f = 0; f < 40; f++) begin
         kind = $urandom_range(0, 9);
         if (kind < 6)      len = FRAME_LEN;
         else if (kind < 8) len = $urandom_range(3, FRAME_LEN - 1);
         else               len = $urandom_range(FRAME_LEN + 1, FRAME_LEN + 40);
         pw = $urandom_range(1, 2);
         for (int i = 0; i < len; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), (i < pw), ($urandom_range(0, 299) == 0));
            n_tests++;
            if ({dut_vec(0), dut_vec(1)} !== {exp_vec(0), exp_vec(1)}) begin
               n_fail++;
               $display("FAIL random_model f=%0d i=%0d got=%b/%b required=%b/%b",
                        f, i, dut_vec(0), dut_vec(1), exp_vec(0), exp_vec(1));
            end
`ifdef SYNC_TRACKER_ERR_CNT_EN
            n_tests++;
            if ({h_ecnt, l_ecnt} !== {8'(m_ecnt), 8'(m_ecnt)}) begin
               n_fail++;
               $display("FAIL random_errcnt got=%0d/%0d required=%0d", h_ecnt, l_ecnt, m_ecnt);
            end
`endif
         end
      end
   endtask

   task automatic test_err_count();
      int n_h, n_l;
      n_h = 0; n_l = 0;
      drive_cycle(1'b0, 1'b0, 1'b1);
      drive_cycle(1'b0, 1'b0, 1'b0);
      drive_run(0, 6);
      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < 6; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), (i < 2), 1'b0);
            n_h += int'(h_err);
            n_l += int'(l_err);
         end
      end
      n_tests++;
      if ({n_h, n_l} !== {32'd300, 32'd300}) begin
         n_fail++;
         $display("FAIL early_pulses got=%0d/%0d required 300", n_h, n_l);
      end
`ifdef SYNC_TRACKER_ERR_CNT_EN
      n_tests++;
      if ({h_ecnt, l_ecnt} !== {8'd255, 8'd255}) begin
         n_fail++;
         $display("FAIL errcnt_sat got=%0d/%0d required 255", h_ecnt, l_ecnt);
      end
      for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b0, 1'b0);
      n_tests++;
      if ({h_ecnt, l_ecnt} !== {8'd255, 8'd255}) begin
         n_fail++;
         $display("FAIL errcnt_hold got=%0d/%0d required 255", h_ecnt, l_ecnt);
      end
      drive_cycle(1'b0, 1'b0, 1'b1);
      n_tests++;
      if ({h_ecnt, l_ecnt} !== 16'd0) begin
         n_fail++;
         $display("FAIL errcnt_clear got=%0d/%0d required 0", h_ecnt, l_ecnt);
      end
`endif
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1; hs = 1'b0; vs = 1'b0;
      test_reset();
      test_clean_frames();
      test_early_frame();
      test_missing_vsync();
      test_mid_reset();
      test_random_frames();
      test_err_count();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
